mem_arbiter: RTL and testbench

Two-requester memory arbiter between the instruction cache and data cache miss/write-back paths and the single shared off-chip memory port. It accepts line-sized read requests from the I-cache and read or write requests from the D-cache, and grants the port to one requester at a time, round-robin on conflict. It registers the command, address and write data toward memory. It returns the read line and a one-cycle ready pulse to the owner.

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/rr_arb2.sv | 23 ++
 rtl/mem_arbiter.sv | 99 +++++++++
 tb/tb_mem_arbiter.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and defaults for the two-requester memory arbiter
package mem_arb_pkg;

  localparam int DEF_ADDR_W = 28;
  localparam int DEF_LINE_W = 128;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2,
    DONE   = 2'd3
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - combinational two-input round-robin pick
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic   req_i,
  input  logic   req_d,
  input  owner_t last_grant,
  output owner_t grant,
  output logic   valid
);

  always_comb begin
    valid = req_i | req_d;
    grant = OWN_I;
    if (req_i && req_d) begin
      // On a tie the side that did not win last time gets the port.
      grant = (last_grant == OWN_I) ? OWN_D : OWN_I;
    end else if (req_d) begin
      grant = OWN_D;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - I/D cache arbiter onto a single shared memory port
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LINE_W = DEF_LINE_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ready,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic              d_ready,
  output logic [LINE_W-1:0] rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  state_t state;
  owner_t last_grant;
  owner_t pick;
  logic   pick_valid;
  logic   req_d;

  assign req_d = d_read | d_write;

  rr_arb2 u_rr_arb2 (
    .req_i      (i_read),
    .req_d      (req_d),
    .last_grant (last_grant),
    .grant      (pick),
    .valid      (pick_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= OWN_I;
      i_ready    <= 1'b0;
      d_ready    <= 1'b0;
      rdata      <= '0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            last_grant <= pick;
            if (pick == OWN_I) begin
              mem_read  <= 1'b1;
              mem_write <= 1'b0;
              mem_addr  <= i_addr;
              state     <= I_BUSY;
            end else begin
              // A simultaneous read+write from D is issued as a write.
              mem_read  <= ~d_write;
              mem_write <= d_write;
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
              state     <= D_BUSY;
            end
          end
        end
        I_BUSY, D_BUSY: begin
          if (mem_ready) begin
            if (mem_read) begin
              rdata <= mem_rdata;
            end
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            if (state == I_BUSY) begin
              i_ready <= 1'b1;
            end else begin
              d_ready <= 1'b1;
            end
            state <= DONE;
          end
        end
        DONE: begin
          i_ready <= 1'b0;
          d_ready <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int AW = DEF_ADDR_W;
  localparam int LW = DEF_LINE_W;
  localparam int LIMIT = 50;

  logic          clk;
  logic          rst_n;
  logic          i_read;
  logic [AW-1:0] i_addr;
  logic          i_ready;
  logic          d_read;
  logic          d_write;
  logic [AW-1:0] d_addr;
  logic [LW-1:0] d_wdata;
  logic          d_ready;
  logic [LW-1:0] rdata;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_addr;
  logic [LW-1:0] mem_wdata;
  logic [LW-1:0] mem_rdata;
  logic          mem_ready;

  int n_pass = 0;
  int n_total = 0;
  int b2b_viol = 0;
  int overlap_viol = 0;
  int i_pulses = 0;
  logic prev_rdy = 1'b0;

  mem_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_read    (i_read),
    .i_addr    (i_addr),
    .i_ready   (i_ready),
    .d_read    (d_read),
    .d_write   (d_write),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_ready   (d_ready),
    .rdata     (rdata),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (i_ready && d_ready) overlap_viol++;
    if ((i_ready || d_ready) && prev_rdy) b2b_viol++;
    if (i_ready) i_pulses++;
    prev_rdy = i_ready | d_ready;
  end

  task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
    mem_ready = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic wait_cmd(input string tag);
    int n = 0;
    while (!(mem_read || mem_write) && n < LIMIT) begin
      step();
      n++;
    end
    check({tag, "_cmd_timeout"}, LW'(n < LIMIT), LW'(1));
  endtask

  task automatic respond(input int lat, input logic [LW-1:0] data);
    repeat (lat - 1) step();
    mem_rdata = data;
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!(i_ready || d_ready) && n < LIMIT) begin
      step();
      n++;
    end
    check({tag, "_rdy_timeout"}, LW'(n < LIMIT), LW'(1));
  endtask

  logic [LW-1:0] a5_line;
  logic [LW-1:0] wline;
  logic [LW-1:0] line5a;
  int            pulses_before;

  initial begin
    a5_line = {16{8'hA5}};
    line5a  = {16{8'h5A}};
    wline   = 128'h1234_5678_9abc_def0_0fed_cba9_8765_4321;
    i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
    apply_reset();

    check("rst_mem_read", LW'(mem_read), LW'(0));
    check("rst_mem_write", LW'(mem_write), LW'(0));
    check("rst_mem_addr", LW'(mem_addr), LW'(0));
    check("rst_rdata", rdata, '0);
    check("rst_readys", LW'({i_ready, d_ready}), LW'(0));

    // I-cache read
    i_read = 1'b1; i_addr = 28'h0000010;
    step();
    check("i_mem_read_n1", LW'(mem_read), LW'(1));
    check("i_mem_addr", LW'(mem_addr), LW'(28'h10));
    respond(4, a5_line);
    wait_ready("i1");
    i_read = 1'b0;
    check("i1_i_ready", LW'(i_ready), LW'(1));
    check("i1_d_ready", LW'(d_ready), LW'(0));
    check("i1_rdata", rdata, a5_line);
    check("i1_cmd_low_done", LW'({mem_read, mem_write}), LW'(0));
    step();
    check("i1_single_pulse", LW'(i_ready), LW'(0));

    // D-cache write
    d_write = 1'b1; d_addr = 28'h20; d_wdata = wline;
    wait_cmd("dw");
    check("dw_mem_write", LW'({mem_read, mem_write}), LW'(2'b01));
    check("dw_mem_addr", LW'(mem_addr), LW'(28'h20));
    check("dw_mem_wdata", mem_wdata, wline);
    respond(2, line5a);
    wait_ready("dw");
    d_write = 1'b0;
    check("dw_d_ready", LW'({i_ready, d_ready}), LW'(2'b01));
    check("dw_rdata_kept", rdata, a5_line);
    step();
    check("dw_single_pulse", LW'(d_ready), LW'(0));

    // Tie right after reset: D then I
    apply_reset();
    i_read = 1'b1; i_addr = 28'h30;
    d_read = 1'b1; d_addr = 28'h40;
    wait_cmd("tie1");
    check("tie1_addr_d", LW'(mem_addr), LW'(28'h40));
    respond(1, {4{32'hD0D0_0001}});
    wait_ready("tie1");
    d_read = 1'b0;
    check("tie1_d_first", LW'({i_ready, d_ready}), LW'(2'b01));
    check("tie1_rdata", rdata, {4{32'hD0D0_0001}});
    step();
    wait_cmd("tie2");
    check("tie2_addr_i", LW'(mem_addr), LW'(28'h30));
    respond(3, {4{32'h1111_0002}});
    wait_ready("tie2");
    i_read = 1'b0;
    check("tie2_i_second", LW'({i_ready, d_ready}), LW'(2'b10));
    check("tie2_rdata", rdata, {4{32'h1111_0002}});
    step();

    // Continuous contention: D, I, D, I
    i_read = 1'b1; i_addr = 28'h50;
    d_read = 1'b1; d_addr = 28'h60;
    for (int k = 0; k < 4; k++) begin
      logic exp_d;
      logic [LW-1:0] data;
      exp_d = (k % 2 == 0);
      data = {4{32'hC000_0000 + 32'(k)}};
      wait_cmd($sformatf("rr%0d", k));
      check($sformatf("rr%0d_addr", k), LW'(mem_addr), exp_d ? LW'(28'h60) : LW'(28'h50));
      respond(2, data);
      wait_ready($sformatf("rr%0d", k));
      check($sformatf("rr%0d_owner", k), LW'({i_ready, d_ready}), exp_d ? LW'(2'b01) : LW'(2'b10));
      check($sformatf("rr%0d_rdata", k), rdata, data);
      step();
    end
    i_read = 1'b0; d_read = 1'b0;
    repeat (2) step();

    // Reset in the middle of an I transaction
    i_read = 1'b1; i_addr = 28'h70;
    wait_cmd("rst_mid");
    step();
    pulses_before = i_pulses;
    rst_n = 1'b0;
    #1;
    check("rst_mid_async_cmd", LW'({mem_read, mem_write}), LW'(0));
    check("rst_mid_async_addr", LW'(mem_addr), LW'(0));
    check("rst_mid_async_rdata", rdata, '0);
    i_read = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    repeat (3) step();
    check("rst_mid_no_i_ready", LW'(i_pulses), LW'(pulses_before));
    i_read = 1'b1;
    wait_cmd("rst_re");
    check("rst_re_addr", LW'(mem_addr), LW'(28'h70));
    respond(2, line5a);
    wait_ready("rst_re");
    i_read = 1'b0;
    check("rst_re_i_ready", LW'({i_ready, d_ready}), LW'(2'b10));
    check("rst_re_rdata", rdata, line5a);
    step();

    // Stray mem_ready in IDLE, then read+write from D
    respond(1, {16{8'hFF}});
    repeat (2) step();
    check("stray_rdata", rdata, line5a);
    check("stray_cmd", LW'({mem_read, mem_write, i_ready, d_ready}), LW'(0));
    d_read = 1'b1; d_write = 1'b1; d_addr = 28'h80; d_wdata = ~wline;
    wait_cmd("rw");
    check("rw_write_only", LW'({mem_read, mem_write}), LW'(2'b01));
    check("rw_wdata", mem_wdata, ~wline);
    respond(2, {16{8'hEE}});
    wait_ready("rw");
    d_read = 1'b0; d_write = 1'b0;
    check("rw_d_ready", LW'({i_ready, d_ready}), LW'(2'b01));
    check("rw_rdata_kept", rdata, line5a);
    repeat (3) step();

    check("no_back_to_back_ready", LW'(b2b_viol), LW'(0));
    check("no_ready_overlap", LW'(overlap_viol), LW'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
